// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: opcode encoding, flag bit positions, FSM states.
// Opcodes 12/13 (ADDS/SUBS) are only legal when ALU_SAT_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_XOR   = 4'd4,
    OP_NEG   = 4'd5,
    OP_SCALE = 4'd6,
    OP_SEL   = 4'd7,
    OP_OR    = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_MUL   = 4'd11,
    OP_ADDS  = 4'd12,
    OP_SUBS  = 4'd13
  } opcode_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ILL   = 4;
  localparam int NUM_FLAGS = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Signed overflow from operand and result sign bits; for subtraction the
  // operands must differ in sign for overflow to be possible.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    if (is_sub)
      return (a_msb != b_msb) && (r_msb != a_msb);
    else
      return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps,
// done asserted for one cycle once the full 2*WIDTH product is ready.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0])
          product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Parametrised ALU with valid/ready handshake, flag vector and iterative MUL.
// Define ALU_SAT_EN to enable signed saturating ADDS/SUBS (else illegal).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     accum,
  input  logic [WIDTH-1:0]     data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     alu_out,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 acc_zero
);

  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t               state;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic [WIDTH-1:0]     scale_val;

  logic [WIDTH-1:0]     res;
  logic                 res_carry;
  logic                 res_ovf;
  logic                 res_ill;
  logic [NUM_FLAGS-1:0] res_flags;
  logic [NUM_FLAGS-1:0] mul_flags;

  assign acc_zero  = (accum == '0);
  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  // Bit WIDTH of the unsigned difference is the borrow (accum < data).
  assign add_full  = {1'b0, accum} + {1'b0, data};
  assign sub_full  = {1'b0, accum} - {1'b0, data};
  assign add_ovf   = signed_ovf(accum[WIDTH-1], data[WIDTH-1], add_full[WIDTH-1], 1'b0);
  assign sub_ovf   = signed_ovf(accum[WIDTH-1], data[WIDTH-1], sub_full[WIDTH-1], 1'b1);
  assign scale_val = (accum << 2) + accum + (accum >> 3);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (accum),
    .b       (data),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_ill   = 1'b0;
    case (opcode)
      OP_PASS:  res = accum;
      OP_ADD: begin
        res       = add_full[WIDTH-1:0];
        res_carry = add_full[WIDTH];
        res_ovf   = add_ovf;
      end
      OP_SUB: begin
        res       = sub_full[WIDTH-1:0];
        res_carry = sub_full[WIDTH];
        res_ovf   = sub_ovf;
      end
      OP_AND:   res = accum & data;
      OP_XOR:   res = accum ^ data;
      OP_NEG:   res = ~accum + 1'b1;
      OP_SCALE: res = scale_val;
      OP_SEL:   res = (|accum[WIDTH-1:WIDTH-3]) ? data : ~data;
      OP_OR:    res = accum | data;
      OP_SHL:   res = accum << data[SHW-1:0];
      OP_SHR:   res = accum >> data[SHW-1:0];
      // MUL results come from the iterative multiplier, not this mux.
      OP_MUL:   res = '0;
`ifdef ALU_SAT_EN
      OP_ADDS: begin
        res_carry = add_full[WIDTH];
        res_ovf   = add_ovf;
        res       = add_ovf ? (accum[WIDTH-1] ? SAT_MIN : SAT_MAX) : add_full[WIDTH-1:0];
      end
      OP_SUBS: begin
        res_carry = sub_full[WIDTH];
        res_ovf   = sub_ovf;
        res       = sub_ovf ? (accum[WIDTH-1] ? SAT_MIN : SAT_MAX) : sub_full[WIDTH-1:0];
      end
`endif
      default:  res_ill = 1'b1;
    endcase

    res_flags            = '0;
    res_flags[FLG_ZERO]  = (res == '0);
    res_flags[FLG_NEG]   = res[WIDTH-1];
    res_flags[FLG_CARRY] = res_carry;
    res_flags[FLG_OVF]   = res_ovf;
    res_flags[FLG_ILL]   = res_ill;
  end

  always_comb begin
    mul_flags            = '0;
    mul_flags[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLG_NEG]   = mul_prod[WIDTH-1];
    mul_flags[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  // A new result written in the same cycle as a drain overrides the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags     <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state <= S_MUL;
            end else begin
              alu_out   <= res;
              flags     <= res_flags;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            alu_out   <= mul_prod[WIDTH-1:0];
            flags     <= mul_flags;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe against an integer-arithmetic model.
// Saturating-op expectations follow the ALU_SAT_EN macro.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] accum;
  logic [W-1:0] data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [4:0]   flags;
  logic         acc_zero;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .accum     (accum),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags),
    .acc_zero  (acc_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, reduced modulo 2^W.
  // Returns {illegal, overflow, carry, negative, zero, result}.
  function automatic logic [W+4:0] model(input int op, input longint a, input longint b);
    longint m    = longint'(1) << W;
    longint half = m >> 1;
    longint r    = 0;
    longint sa, sb, s;
    logic c = 1'b0, v = 1'b0, ill = 1'b0;
    logic [W-1:0] rv;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    case (op)
      0:  r = a;
      1:  begin r = a + b; c = (r >= m); s = sa + sb; v = (s >= half) || (s < -half); end
      2:  begin r = a - b; c = (a < b);  s = sa - sb; v = (s >= half) || (s < -half); end
      3:  r = a & b;
      4:  r = a ^ b;
      5:  r = m - a;
      6:  r = 4 * a + a + a / 8;
      7:  r = ((a >> (W - 3)) != 0) ? b : (m - 1 - b);
      8:  r = a | b;
      9:  r = a << (b % W);
      10: r = a >> (b % W);
      11: begin r = a * b; c = (r >= m); end
`ifdef ALU_SAT_EN
      12, 13: begin
        s = (op == 12) ? sa + sb : sa - sb;
        c = (op == 12) ? (a + b >= m) : (a < b);
        if (s > half - 1) begin s = half - 1; v = 1'b1; end
        else if (s < -half) begin s = -half; v = 1'b1; end
        r = s;
      end
`endif
      default: ill = 1'b1;
    endcase
    r  = ((r % m) + m) % m;
    rv = r[W-1:0];
    return {ill, v, c, rv[W-1], (rv == '0), rv};
  endfunction

  // Issue one op with out_ready held high; checks latency, busy window and result.
  task automatic do_op(input string tag, input int op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [4:0] ef);
    @(negedge clk);
    opcode = op[3:0]; accum = a; data = b; in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs after accept: results must come from captured operands.
    opcode = 4'($urandom); accum = W'($urandom); data = W'($urandom);
    if (op == 11) begin
      check({tag, " busy0"}, {in_ready, out_valid}, 2'b00);
      for (int i = 1; i <= W; i++) begin
        @(posedge clk); #1;
        check($sformatf("%s busy%0d", tag, i), {in_ready, out_valid}, 2'b00);
      end
    end
    in_valid = 1'b0;
    if (op == 11) begin
      @(posedge clk); #1;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " alu_out"}, alu_out, er);
    check({tag, " flags"}, flags, ef);
    $display("op=%0d a=0x%02h b=0x%02h -> alu_out=0x%02h flags=%05b", op, a, b, alu_out, flags);
  endtask

  task automatic do_model_op(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+4:0] e;
    e = model(op, longint'(a), longint'(b));
    do_op(tag, op, a, b, e[W-1:0], e[W+4:W]);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] edges [4];
    edges[0] = '0; edges[1] = '1; edges[2] = 8'h80; edges[3] = 8'h7F;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; accum = '0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset alu_out", alu_out, 0);
    check("reset flags", flags, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("acc_zero 0", acc_zero, 1);
    accum = 8'h40; #1;
    check("acc_zero 40", acc_zero, 0);
    @(negedge clk) reset = 1'b0;

    do_op("add_carry", 1, 8'hF0, 8'h20, 8'h10, 5'b00100);
    @(posedge clk); #1;
    check("add_carry one_cycle", out_valid, 0);
    do_op("add_ovf", 1, 8'h7F, 8'h01, 8'h80, 5'b01010);
    do_op("sub_borrow", 2, 8'h50, 8'h70, 8'hE0, 5'b00110);
    do_op("scale", 6, 8'h10, 8'h00, 8'h52, 5'b00000);
    do_op("sel_b", 7, 8'h20, 8'h3C, 8'h3C, 5'b00000);
    do_op("sel_nb", 7, 8'h1F, 8'h3C, 8'hC3, 5'b00010);
    do_op("mul_8f", 11, 8'h0D, 8'h0B, 8'h8F, 5'b00010);
    do_op("mul_hi", 11, 8'h10, 8'h10, 8'h00, 5'b00101);
    do_op("illegal14", 14, 8'h55, 8'h66, 8'h00, 5'b10001);
`ifdef ALU_SAT_EN
    do_op("adds_sat", 12, 8'h7F, 8'h7F, 8'h7F, 5'b01000);
    do_op("subs_sat", 13, 8'h80, 8'h01, 8'h80, 5'b01010);
`else
    do_op("adds_ill", 12, 8'h7F, 8'h7F, 8'h00, 5'b10001);
    do_op("subs_ill", 13, 8'h80, 8'h01, 8'h00, 5'b10001);
`endif

    // Backpressure: hold the ADD result while a SUB request waits.
    repeat (2) @(posedge clk);
    @(negedge clk) out_ready = 1'b0;
    do_op("bp_add", 1, 8'h33, 8'h44, 8'h77, 5'b00000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd2; accum = 8'h10; data = 8'h20;
      @(posedge clk); #1;
      check($sformatf("bp hold%0d", i), {out_valid, in_ready, alu_out, flags}, {1'b1, 1'b0, 8'h77, 5'b00000});
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp drain_accept", {out_valid, alu_out, flags}, {1'b1, 8'hF0, 5'b00110});
    $display("backpressure release -> alu_out=0x%02h flags=%05b", alu_out, flags);

    // Reset four edges into a MUL: the operation is abandoned.
    @(negedge clk);
    opcode = 4'd11; accum = 8'h0D; data = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mulrst out_valid", out_valid, 0);
    check("mulrst in_ready", in_ready, 1);
    @(negedge clk) reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mulrst no_result", {out_valid, alu_out}, {1'b0, 8'h00});
    $display("reset mid-MUL -> out_valid=%0b alu_out=0x%02h", out_valid, alu_out);
    do_op("mul_after_rst", 11, 8'h03, 8'h05, 8'h0F, 5'b00000);

    for (int i = 0; i < 120; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = edges[$urandom_range(0, 3)];
      do_model_op($sformatf("rnd%0d", i), int'($urandom_range(0, 15)), ra, rb);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
